// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: the S-box (also used by the encrypt stage's SubBytes),
// xtime, the rcon seed, and the key-schedule FSM state encoding.
package aes_pkg;

    localparam int         AES_NR      = 10;
    localparam int         AES_BLOCK_W = 128;
    localparam logic [7:0] RCON_INIT   = 8'h01;

    typedef enum logic [1:0] {
        KE_IDLE   = 2'd0,
        KE_EXPAND = 2'd1,
        KE_DONE   = 2'd2
    } ke_state_e;

    // Ascending packed range so SBOX[b] is the table entry for input byte b.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational RotWord followed by SubWord on one 32-bit key-schedule word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] w,
    output logic [31:0] sw
);

    logic [31:0] rot;

    assign rot = {w[23:0], w[31:24]};

    assign sw = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: one round key per clock into an 11-entry store with a registered read port.
// Optional build macro KEYEXP_ZEROIZE_EN adds a zeroize input that wipes all key material.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR     = 10,
    parameter int RIDX_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [127:0]      key_in,
    input  logic              key_valid,
    output logic              key_ready,
    output logic              busy,
    output logic              keys_ready,
    input  logic [RIDX_W-1:0] rd_round,
`ifdef KEYEXP_ZEROIZE_EN
    input  logic              zeroize,
`endif
    output logic [127:0]      rd_key
);

    generate
        if (NR != AES_NR) begin : g_nr_check
            $error("aes_key_expand supports only NR = 10 (AES-128)");
        end
    endgenerate

    localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(NR);

    ke_state_e                   state;
    logic [AES_BLOCK_W-1:0]      rk [0:NR];
    logic [AES_BLOCK_W-1:0]      prev;
    logic [AES_BLOCK_W-1:0]      next_key;
    logic [7:0]                  rcon;
    logic [RIDX_W-1:0]           round;
    logic                        key_ready_q;
    logic                        zero_req;
    logic                        load;
    logic [31:0]                 sw, t, n0, n1, n2, n3;

`ifdef KEYEXP_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    // A zeroize cycle must never acknowledge a key.
    assign key_ready = key_ready_q & ~zero_req;
    assign load      = key_valid & key_ready;

    aes_sub_word u_sub_word (
        .w  (prev[31:0]),
        .sw (sw)
    );

    assign t        = sw ^ {rcon, 24'h0};
    assign n0       = prev[127:96] ^ t;
    assign n1       = prev[95:64]  ^ n0;
    assign n2       = prev[63:32]  ^ n1;
    assign n3       = prev[31:0]   ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_ff @(posedge clk) begin
        if (reset || zero_req) begin
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
            prev        <= '0;
            rd_key      <= '0;
            rcon        <= RCON_INIT;
            round       <= '0;
            state       <= KE_IDLE;
            key_ready_q <= 1'b1;
            busy        <= 1'b0;
            keys_ready  <= 1'b0;
        end else begin
            // Read-before-write: a same-edge write to rd_round is seen next cycle.
            rd_key <= (rd_round <= LAST_ROUND) ? rk[rd_round] : '0;
            case (state)
                KE_EXPAND: begin
                    rk[round] <= next_key;
                    prev      <= next_key;
                    rcon      <= xtime(rcon);
                    round     <= round + 1'b1;
                    if (round == LAST_ROUND) begin
                        state       <= KE_DONE;
                        busy        <= 1'b0;
                        keys_ready  <= 1'b1;
                        key_ready_q <= 1'b1;
                    end
                end
                default: begin
                    if (load) begin
                        rk[0]       <= key_in;
                        prev        <= key_in;
                        round       <= RIDX_W'(1);
                        rcon        <= RCON_INIT;
                        keys_ready  <= 1'b0;
                        busy        <= 1'b1;
                        key_ready_q <= 1'b0;
                        state       <= KE_EXPAND;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand using FIPS-197 vectors; build with +define+KEYEXP_ZEROIZE_EN
// to also cover zeroize.
module tb_aes_key_expand;

    localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    // Status triples are {key_ready, busy, keys_ready}.
    localparam logic [2:0]   ST_IDLE = 3'b100;
    localparam logic [2:0]   ST_BUSY = 3'b010;
    localparam logic [2:0]   ST_DONE = 3'b101;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready, busy, keys_ready;
    logic [3:0]   rd_round = '0;
    logic [127:0] rd_key;
    logic         zeroize = 1'b0;

    typedef struct {
        string        name;
        logic         chk_key;
        logic [127:0] key;
        logic         chk_st;
        logic [2:0]   st;
    } exp_t;

    exp_t exp_q[$];
    logic rd_issue  = 1'b0;
    logic rd_vld_p1 = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_done = 1'b0;

    always #5 clk = ~clk;

    aes_key_expand #(.NR(10), .RIDX_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_ready (keys_ready),
        .rd_round   (rd_round),
`ifdef KEYEXP_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .rd_key     (rd_key)
    );

    always @(posedge clk) rd_vld_p1 <= rd_issue;

    // Monitor: pops one expectation for every cycle the stimulus flagged.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_vld_p1 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard_underflow: output flagged with no expectation queued");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.chk_key) begin
                        n_cmp++;
                        if (rd_key !== e.key) begin
                            n_bad++;
                            $display("FAIL %s rd_key: got %h want %h", e.name, rd_key, e.key);
                        end
                    end
                    if (e.chk_st) begin
                        n_cmp++;
                        if ({key_ready, busy, keys_ready} !== e.st) begin
                            n_bad++;
                            $display("FAIL %s status{key_ready,busy,keys_ready}: got %b want %b",
                                     e.name, {key_ready, busy, keys_ready}, e.st);
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expectation applies to what the DUT shows after the next rising edge.
    task automatic check(input string name, input logic [3:0] r, input logic ck, input logic [127:0] k,
                         input logic cs, input logic [2:0] st);
        exp_t e;
        e.name = name; e.chk_key = ck; e.key = k; e.chk_st = cs; e.st = st;
        exp_q.push_back(e);
        rd_round = r;
        rd_issue = 1'b1;
        @(posedge clk);
        #1;
        rd_issue = 1'b0;
    endtask

    task automatic load(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        step(1);
        key_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("reset_state", 4'd0, 1'b1, '0, 1'b1, ST_IDLE);
        reset = 1'b0;
        check("idle_after_reset", 4'd5, 1'b1, '0, 1'b1, ST_IDLE);

        // 1: FIPS-197 key, check timing of keys_ready and two round keys.
        load(KEY_A);
        check("t1_edge1", 4'd0, 1'b0, '0, 1'b1, ST_BUSY);
        step(7);
        check("t1_edge9", 4'd0, 1'b0, '0, 1'b1, ST_BUSY);
        check("t1_edge10", 4'd0, 1'b0, '0, 1'b1, ST_DONE);
        check("t1_rk1", 4'd1, 1'b1, A_RK1, 1'b1, ST_DONE);
        check("t1_rk10", 4'd10, 1'b1, A_RK10, 1'b0, '0);
        check("t1_rk0", 4'd0, 1'b1, KEY_A, 1'b0, '0);

        // 2: all-zero key.
        load('0);
        step(10);
        check("t2_rk1", 4'd1, 1'b1, Z_RK1, 1'b1, ST_DONE);
        check("t2_rk10", 4'd10, 1'b1, Z_RK10, 1'b0, '0);
        check("t2_rk0", 4'd0, 1'b1, '0, 1'b0, '0);

        // 3: key_valid pulse during EXPAND is ignored.
        load(KEY_A);
        step(2);
        key_in    = '0;
        key_valid = 1'b1;
        check("t3_pulse_edge3", 4'd0, 1'b0, '0, 1'b1, ST_BUSY);
        key_valid = 1'b0;
        step(5);
        check("t3_edge9", 4'd0, 1'b0, '0, 1'b1, ST_BUSY);
        check("t3_edge10", 4'd0, 1'b0, '0, 1'b1, ST_DONE);
        check("t3_rk10", 4'd10, 1'b1, A_RK10, 1'b0, '0);
        check("t3_rk1", 4'd1, 1'b1, A_RK1, 1'b0, '0);

        // 4: reset at edge 5 of an expansion.
        load(KEY_A);
        step(4);
        reset = 1'b1;
        check("t4_reset_edge5", 4'd3, 1'b1, '0, 1'b1, ST_IDLE);
        reset = 1'b0;
        check("t4_after_reset_rk3", 4'd3, 1'b1, '0, 1'b1, ST_IDLE);

        // 5: reload from DONE while reading rk0 on the accept edge.
        load(KEY_A);
        step(10);
        key_in    = '0;
        key_valid = 1'b1;
        check("t5_accept_old_rk0", 4'd0, 1'b1, KEY_A, 1'b1, ST_BUSY);
        key_valid = 1'b0;
        step(9);
        check("t5_edge10", 4'd0, 1'b0, '0, 1'b1, ST_DONE);
        check("t5_rk10", 4'd10, 1'b1, Z_RK10, 1'b0, '0);
        check("t5_rk0", 4'd0, 1'b1, '0, 1'b0, '0);

        // 6: out-of-range indices read as zero.
        check("t6_rd11", 4'd11, 1'b1, '0, 1'b1, ST_DONE);
        check("t6_rd15", 4'd15, 1'b1, '0, 1'b0, '0);
`ifdef KEYEXP_ZEROIZE_EN
        check("t6_rk10_before_zeroize", 4'd10, 1'b1, Z_RK10, 1'b0, '0);
        load(KEY_A);
        step(10);
        zeroize   = 1'b1;
        key_in    = KEY_A;
        key_valid = 1'b1;
        step(1);
        zeroize   = 1'b0;
        key_valid = 1'b0;
        check("t6_zeroize_rk10", 4'd10, 1'b1, '0, 1'b1, ST_IDLE);
        check("t6_zeroize_rk0", 4'd0, 1'b1, '0, 1'b1, ST_IDLE);
`endif

        step(2);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
